// File: rtl/basket_pkg.sv
// basket_pkg: shared widths, slot record, FSM state encoding and the
// saturating quantity adder applied when an add hits an existing slot.
package basket_pkg;

  localparam int ID_W          = 4;
  localparam int QTY_W         = 4;
  localparam int QTY_MAX       = 15;
  localparam int NUM_PRODUCTS  = 12;
  localparam int MAX_ITEMS_DEF = 8;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [QTY_W-1:0] qty;
  } slot_t;

  typedef enum logic [1:0] {
    B_IDLE   = 2'd0,
    B_SEARCH = 2'd1,
    B_WRITE  = 2'd2,
    B_SHIFT  = 2'd3
  } state_e;

  // One bit of headroom so the carry is visible before clamping.
  function automatic logic [QTY_W-1:0] sat_add(input logic [QTY_W-1:0] a,
                                               input logic [QTY_W-1:0] b);
    logic [QTY_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > (QTY_W+1)'(QTY_MAX))
      sat_add = (QTY_W)'(QTY_MAX);
    else
      sat_add = sum[QTY_W-1:0];
  endfunction

  function automatic logic id_valid(input logic [ID_W-1:0] id);
    id_valid = ({1'b0, id} < (ID_W+1)'(NUM_PRODUCTS));
  endfunction

endpackage

// File: rtl/basket_if.sv
// basket_if: command, result-pulse and read-port signals between the
// terminal state machine (master) and the basket store (slave).
interface basket_if
  import basket_pkg::*;
#(
  parameter int MAX_ITEMS = MAX_ITEMS_DEF
);

  localparam int IDX_W = $clog2(MAX_ITEMS);
  localparam int CNT_W = IDX_W + 1;

  logic              Add_En;
  logic [ID_W-1:0]   ProductID_in;
  logic [QTY_W-1:0]  ProductQuantity_in;
  logic              Cancel_En;
  logic [IDX_W-1:0]  Cancel_Index;
  logic              Clear;
  logic [IDX_W-1:0]  Rd_Index;
  logic [ID_W-1:0]   Rd_ProductID;
  logic [QTY_W-1:0]  Rd_Quantity;
  logic              Rd_Valid;
  logic [CNT_W-1:0]  BasketProductNum;
  logic              Full;
  logic              Busy;
  logic              Add_Ack;
  logic              Add_Err;
  logic              Cancel_Ack;
  logic              Cancel_Err;

  modport master (
    output Add_En, ProductID_in, ProductQuantity_in, Cancel_En, Cancel_Index,
           Clear, Rd_Index,
    input  Rd_ProductID, Rd_Quantity, Rd_Valid, BasketProductNum, Full, Busy,
           Add_Ack, Add_Err, Cancel_Ack, Cancel_Err
  );

  modport slave (
    input  Add_En, ProductID_in, ProductQuantity_in, Cancel_En, Cancel_Index,
           Clear, Rd_Index,
    output Rd_ProductID, Rd_Quantity, Rd_Valid, BasketProductNum, Full, Busy,
           Add_Ack, Add_Err, Cancel_Ack, Cancel_Err
  );

endinterface

// File: rtl/basket_slot_array.sv
// basket_slot_array: MAX_ITEMS x {id,qty} register file with a single
// write port, clear-all, and two combinational read ports (one for the
// display/total consumers, one for the controller's own search/shift).
module basket_slot_array
  import basket_pkg::*;
#(
  parameter int MAX_ITEMS = MAX_ITEMS_DEF,
  localparam int IDX_W = $clog2(MAX_ITEMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_index,
  input  slot_t            wr_data,
  input  logic [IDX_W-1:0] rd_index_a,
  output slot_t            rd_data_a,
  input  logic [IDX_W-1:0] rd_index_b,
  output slot_t            rd_data_b
);

  slot_t slots [MAX_ITEMS];

  // Storage: reset and clear zero every slot, otherwise one slot per edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < MAX_ITEMS; k++)
        slots[k] <= '0;
    end else if (we) begin
      slots[wr_index] <= wr_data;
    end
  end

  assign rd_data_a = slots[rd_index_a];
  assign rd_data_b = slots[rd_index_b];

endmodule

// File: rtl/basket_controller.sv
// basket_controller: compacted product list with merge-on-add, saturating
// quantities and delete-with-shift, sequenced one slot per clock.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   S_IDLE    | waiting for Clear / Cancel_En / Add_En
//   S_SEARCH  | scanning slot idx for the latched product id
//   S_WRITE   | merge into hit slot, append on miss, or report full
//   S_SHIFT   | moving slot idx+1 down to idx; last edge zeroes tail
module basket_controller
  import basket_pkg::*;
#(
  parameter int MAX_ITEMS = MAX_ITEMS_DEF
) (
  input  logic     CLOCK_50,
  input  logic     RESET,
  basket_if.slave  bus
);

  localparam int IDX_W = $clog2(MAX_ITEMS);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] S_IDLE   = B_IDLE;
  localparam logic [1:0] S_SEARCH = B_SEARCH;
  localparam logic [1:0] S_WRITE  = B_WRITE;
  localparam logic [1:0] S_SHIFT  = B_SHIFT;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITEMS);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  lat_id;
  logic [QTY_W-1:0] lat_qty;
  logic             hit;
  logic             add_ack, add_err, cancel_ack, cancel_err;

  logic             arr_we;
  logic [IDX_W-1:0] arr_wr_index;
  slot_t            arr_wr_data;
  logic [IDX_W-1:0] rd_index_int;
  slot_t            int_slot;
  slot_t            rd_slot;

  logic             full;
  logic             search_hit;
  logic             search_last;
  logic             shift_more;

  assign full        = (count == CNT_MAX);
  assign search_hit  = ({1'b0, idx} < count) && (int_slot.id == lat_id);
  assign search_last = (({1'b0, idx} + CNT_ONE) >= count);
  assign shift_more  = ({1'b0, idx} < (count - CNT_ONE));

  basket_slot_array #(.MAX_ITEMS(MAX_ITEMS)) u_slots (
    .clk        (CLOCK_50),
    .rst        (RESET),
    .clear      (bus.Clear),
    .we         (arr_we),
    .wr_index   (arr_wr_index),
    .wr_data    (arr_wr_data),
    .rd_index_a (bus.Rd_Index),
    .rd_data_a  (rd_slot),
    .rd_index_b (rd_index_int),
    .rd_data_b  (int_slot)
  );

  // Slot write port and internal read address for the current state.
  always_comb begin
    arr_we       = 1'b0;
    arr_wr_index = idx;
    arr_wr_data  = '0;
    rd_index_int = idx;
    case (state)
      S_WRITE: begin
        if (hit) begin
          arr_we      = 1'b1;
          arr_wr_data = {lat_id, sat_add(int_slot.qty, lat_qty)};
        end else if (!full) begin
          arr_we       = 1'b1;
          arr_wr_index = count[IDX_W-1:0];
          arr_wr_data  = {lat_id, lat_qty};
        end
      end
      S_SHIFT: begin
        // On the final edge idx == count-1, so this zeroes the tail slot.
        rd_index_int = idx + IDX_ONE;
        arr_we       = 1'b1;
        arr_wr_data  = shift_more ? int_slot : slot_t'('0);
      end
      default: ;
    endcase
  end

  // Sequencer: command decode, scan/shift stepping, count and result pulses.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state      <= S_IDLE;
      idx        <= '0;
      count      <= '0;
      lat_id     <= '0;
      lat_qty    <= '0;
      hit        <= 1'b0;
      add_ack    <= 1'b0;
      add_err    <= 1'b0;
      cancel_ack <= 1'b0;
      cancel_err <= 1'b0;
    end else begin
      add_ack    <= 1'b0;
      add_err    <= 1'b0;
      cancel_ack <= 1'b0;
      cancel_err <= 1'b0;
      if (bus.Clear) begin
        state <= S_IDLE;
        idx   <= '0;
        count <= '0;
        hit   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.Cancel_En) begin
              if ({1'b0, bus.Cancel_Index} >= count) begin
                cancel_err <= 1'b1;
              end else begin
                idx   <= bus.Cancel_Index;
                state <= S_SHIFT;
              end
            end else if (bus.Add_En) begin
              if (!id_valid(bus.ProductID_in) || (bus.ProductQuantity_in == '0)) begin
                add_err <= 1'b1;
              end else begin
                lat_id  <= bus.ProductID_in;
                lat_qty <= bus.ProductQuantity_in;
                idx     <= '0;
                hit     <= 1'b0;
                state   <= S_SEARCH;
              end
            end
          end
          S_SEARCH: begin
            if (search_hit) begin
              hit   <= 1'b1;
              state <= S_WRITE;
            end else if (search_last) begin
              hit   <= 1'b0;
              state <= S_WRITE;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
          S_WRITE: begin
            if (hit) begin
              add_ack <= 1'b1;
            end else if (!full) begin
              count   <= count + CNT_ONE;
              add_ack <= 1'b1;
            end else begin
              add_err <= 1'b1;
            end
            state <= S_IDLE;
          end
          S_SHIFT: begin
            if (shift_more) begin
              idx <= idx + IDX_ONE;
            end else begin
              count      <= count - CNT_ONE;
              cancel_ack <= 1'b1;
              state      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.Rd_ProductID     = rd_slot.id;
  assign bus.Rd_Quantity      = rd_slot.qty;
  assign bus.Rd_Valid         = ({1'b0, bus.Rd_Index} < count);
  assign bus.BasketProductNum = count;
  assign bus.Full             = full;
  assign bus.Busy             = (state != S_IDLE);
  assign bus.Add_Ack          = add_ack;
  assign bus.Add_Err          = add_err;
  assign bus.Cancel_Ack       = cancel_ack;
  assign bus.Cancel_Err       = cancel_err;

endmodule

// File: tb/tb_basket_controller.sv
// tb_basket_controller: directed commands with hand-computed result pulses
// and commit cycles queued in a scoreboard; a monitor compares every pulse.
`timescale 1ns/1ps
module tb_basket_controller;
  import basket_pkg::*;

  localparam int MI = 8;
  localparam logic [3:0] P_AACK = 4'b0001;
  localparam logic [3:0] P_AERR = 4'b0010;
  localparam logic [3:0] P_CACK = 4'b0100;
  localparam logic [3:0] P_CERR = 4'b1000;

  typedef struct {
    logic [3:0] pulses;
    int         cyc;
    int         tag;
  } exp_t;

  exp_t sb[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   tag = 0;

  basket_if #(.MAX_ITEMS(MI)) bus();

  basket_controller #(.MAX_ITEMS(MI)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [3:0] seen;
    exp_t e;
    seen = {bus.Cancel_Err, bus.Cancel_Ack, bus.Add_Err, bus.Add_Ack};
    if (seen != 4'b0000) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, seen);
      end else begin
        e = sb.pop_front();
        if (seen !== e.pulses || cyc != e.cyc) begin
          bad++;
          $display("FAIL resp_%0d got pulses=%b cyc=%0d required pulses=%b cyc=%0d",
                   e.tag, seen, cyc, e.pulses, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic chk_slot(input int i, input int id, input int qty);
    bus.Rd_Index = 3'(i);
    #1;
    chk($sformatf("slot%0d_id", i), 32'(bus.Rd_ProductID), 32'(id));
    chk($sformatf("slot%0d_qty", i), 32'(bus.Rd_Quantity), 32'(qty));
    chk($sformatf("slot%0d_valid", i), 32'(bus.Rd_Valid), 32'd1);
  endtask

  task automatic chk_free(input int i);
    bus.Rd_Index = 3'(i);
    #1;
    chk($sformatf("free%0d_valid", i), 32'(bus.Rd_Valid), 32'd0);
    chk($sformatf("free%0d_data", i), 32'({bus.Rd_ProductID, bus.Rd_Quantity}), 32'd0);
  endtask

  task automatic chk_count(input int n);
    chk("count", 32'(bus.BasketProductNum), 32'(n));
    chk("full", 32'(bus.Full), (n == MI) ? 32'd1 : 32'd0);
    chk("busy_idle", 32'(bus.Busy), 32'd0);
  endtask

  task automatic push(input logic [3:0] p, input int lat);
    exp_t e;
    tag++;
    e.pulses = p;
    e.cyc    = cyc + 1 + lat;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  task automatic pulse_add(input int id, input int qty);
    @(negedge clk);
    bus.Add_En             = 1'b1;
    bus.ProductID_in       = 4'(id);
    bus.ProductQuantity_in = 4'(qty);
    @(negedge clk);
    bus.Add_En = 1'b0;
  endtask

  task automatic pulse_cancel(input int i);
    @(negedge clk);
    bus.Cancel_En    = 1'b1;
    bus.Cancel_Index = 3'(i);
    @(negedge clk);
    bus.Cancel_En = 1'b0;
  endtask

  // lat = edges after the sampling edge E0 at which the pulse is registered.
  task automatic issue_add(input int id, input int qty, input logic [3:0] p, input int lat);
    @(negedge clk);
    push(p, lat);
    bus.Add_En             = 1'b1;
    bus.ProductID_in       = 4'(id);
    bus.ProductQuantity_in = 4'(qty);
    @(negedge clk);
    bus.Add_En = 1'b0;
    chk("busy_after_add", 32'(bus.Busy), (lat != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic issue_cancel(input int i, input logic [3:0] p, input int lat);
    @(negedge clk);
    push(p, lat);
    bus.Cancel_En    = 1'b1;
    bus.Cancel_Index = 3'(i);
    @(negedge clk);
    bus.Cancel_En = 1'b0;
    chk("busy_after_cancel", 32'(bus.Busy), (lat != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.Busy !== 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL wait_idle timeout got pending=%0d busy=%b required pending=0 busy=0",
               sb.size(), bus.Busy);
      sb.delete();
    end
  endtask

  task automatic add(input int id, input int qty, input logic [3:0] p, input int lat);
    issue_add(id, qty, p, lat);
    wait_idle();
  endtask

  task automatic cancel(input int i, input logic [3:0] p, input int lat);
    issue_cancel(i, p, lat);
    wait_idle();
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.Clear = 1'b1;
    @(negedge clk);
    bus.Clear = 1'b0;
  endtask

  initial begin
    bus.Add_En = 1'b0;
    bus.ProductID_in = '0;
    bus.ProductQuantity_in = '0;
    bus.Cancel_En = 1'b0;
    bus.Cancel_Index = '0;
    bus.Clear = 1'b0;
    bus.Rd_Index = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk_count(0);
    chk_free(0);

    // First add into an empty basket: commit two edges after sampling.
    add(3, 2, P_AACK, 2);
    chk_slot(0, 3, 2);
    chk_count(1);

    // Miss with one entry, then merge into slot 0.
    add(5, 1, P_AACK, 2);
    add(3, 4, P_AACK, 2);
    chk_slot(0, 3, 6);
    chk_slot(1, 5, 1);
    chk_count(2);

    // Saturation: append at slot 2, then four hits at slot 2 (4,8,12,15,15).
    add(7, 4, P_AACK, 3);
    for (int k = 0; k < 4; k++) add(7, 4, P_AACK, 4);
    chk_slot(2, 7, 15);
    chk_count(3);

    // Fill with IDs 0..7; miss latency is 1 + max(count,1).
    do_clear();
    chk_count(0);
    for (int k = 0; k < 8; k++) add(k, 1, P_AACK, 1 + ((k == 0) ? 1 : k));
    chk_count(8);
    add(9, 1, P_AERR, 9);
    chk_count(8);
    chk_slot(7, 7, 1);
    add(2, 3, P_AACK, 4);
    chk_slot(2, 2, 4);
    chk_count(8);

    // Cancel with compaction.
    do_clear();
    add(1, 1, P_AACK, 2);
    add(4, 2, P_AACK, 2);
    add(6, 3, P_AACK, 3);
    add(8, 4, P_AACK, 4);
    cancel(1, P_CACK, 3);
    chk_slot(0, 1, 1);
    chk_slot(1, 6, 3);
    chk_slot(2, 8, 4);
    chk_free(3);
    chk_count(3);
    cancel(5, P_CERR, 0);
    chk_count(3);
    cancel(2, P_CACK, 1);
    chk_free(2);
    chk_count(2);

    // Input rejects.
    add(13, 1, P_AERR, 0);
    add(4, 0, P_AERR, 0);
    chk_count(2);

    // Add_En during SEARCH is dropped: only the first add is acknowledged.
    issue_add(9, 1, P_AACK, 3);
    pulse_add(10, 1);
    wait_idle();
    chk_slot(2, 9, 1);
    chk_count(3);

    // Clear during SHIFT: no Cancel_Ack, basket emptied.
    pulse_cancel(0);
    do_clear();
    repeat (6) @(negedge clk);
    chk_count(0);
    chk_free(0);

    // RESET during SEARCH.
    add(2, 1, P_AACK, 2);
    add(3, 1, P_AACK, 2);
    add(4, 1, P_AACK, 3);
    pulse_add(11, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk_count(0);
    chk_free(0);
    chk_free(1);
    add(5, 3, P_AACK, 2);
    chk_slot(0, 5, 3);
    chk_count(1);

    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations got=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
